gray_code_counter: RTL and testbench

- Synchronous N-bit up/down counter that emits its count in both binary and Gray form; sits directly upstream of binary_to_gray consumers and of Gray-coded pointer/sequence logic.
- Internal state is binary; the Gray output is registered alongside it, so both are glitch-free and update in the same cycle.
- Provides a synchronous load, a one-cycle wrap pulse, and a sticky self-check flag that fires if consecutive Gray outputs ever differ by other than one bit.

---
 rtl/gray_code_counter.sv | 98 +++++++++
 tb/tb_gray_code_counter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// N-bit up/down counter with registered binary and Gray outputs, a wrap pulse,
// and a sticky flag that trips if consecutive Gray values differ by other than one bit.
module gray_code_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] binary,
  output logic [N-1:0] gray,
  output logic         wrap,
  output logic         step_err
);

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ONES = '1;

  logic [N-1:0] binary_reg, binary_next;
  logic [N-1:0] gray_reg, gray_next;
  logic [N-1:0] prev_gray_reg;
  logic [N-1:0] gray_diff;
  logic         wrap_reg, wrap_next;
  logic         step_err_reg, step_err_next;
  logic         check_ok_reg, check_ok_next;
  logic         count_step;
  logic         single_bit;

  assign count_step = en & ~load;

  always_comb begin
    binary_next = binary_reg;
    wrap_next   = 1'b0;
    if (load) begin
      binary_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        binary_next = binary_reg + ONE;
        wrap_next   = (binary_reg == ONES);
      end else begin
        binary_next = binary_reg - ONE;
        wrap_next   = (binary_reg == '0);
      end
    end
  end

  // Gray is derived from the next binary value so both registers move together.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_gray
      assign gray_next[gi] = binary_next[gi] ^ binary_next[gi+1];
    end
  endgenerate
  assign gray_next[N-1] = binary_next[N-1];

  // Exactly one set bit: non-zero, and clearing the lowest set bit leaves zero.
  assign gray_diff  = gray_next ^ prev_gray_reg;
  assign single_bit = (|gray_diff) & ~(|(gray_diff & (gray_diff - ONE)));

  always_comb begin
    check_ok_next = check_ok_reg;
    step_err_next = step_err_reg;
    if (load) begin
      check_ok_next = 1'b0;
    end else if (count_step) begin
      check_ok_next = 1'b1;
      if (check_ok_reg && !single_bit) begin
        step_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      binary_reg    <= '0;
      gray_reg      <= '0;
      prev_gray_reg <= '0;
      wrap_reg      <= 1'b0;
      step_err_reg  <= 1'b0;
      check_ok_reg  <= 1'b0;
    end else begin
      binary_reg    <= binary_next;
      gray_reg      <= gray_next;
      prev_gray_reg <= gray_next;
      wrap_reg      <= wrap_next;
      step_err_reg  <= step_err_next;
      check_ok_reg  <= check_ok_next;
    end
  end

  assign binary   = binary_reg;
  assign gray     = gray_reg;
  assign wrap     = wrap_reg;
  assign step_err = step_err_reg;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed and random stimulus for gray_code_counter; expected outputs are queued
// by a reference model when inputs are driven and popped after each clock edge.
module tb_gray_code_counter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, up_dn, load;
  logic [N-1:0] load_val;
  logic [N-1:0] binary, gray;
  logic         wrap, step_err;

  typedef struct packed {
    logic [N-1:0] bin;
    logic [N-1:0] gry;
    logic         wrp;
    logic         err;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] m_bin = '0;
  logic         m_wrap = 1'b0;
  int           n_asserts = 0;
  int           n_fail = 0;

  gray_code_counter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .binary(binary), .gray(gray), .wrap(wrap),
    .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic step(input logic rn, input logic e, input logic u,
                      input logic l, input logic [N-1:0] lv, input string tag);
    exp_t ex;
    @(negedge clk);
    rst_n = rn; en = e; up_dn = u; load = l; load_val = lv;
    if (!rn) begin
      m_bin = '0; m_wrap = 1'b0;
    end else if (l) begin
      m_bin = lv; m_wrap = 1'b0;
    end else if (e) begin
      m_wrap = u ? (m_bin == 8'hFF) : (m_bin == 8'h00);
      m_bin  = u ? m_bin + 8'd1 : m_bin - 8'd1;
    end else begin
      m_wrap = 1'b0;
    end
    ex.bin = m_bin;
    ex.gry = m_bin ^ (m_bin >> 1);
    ex.wrp = m_wrap;
    ex.err = 1'b0;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb_q.pop_front();
    chk({tag, ".binary"}, binary, ex.bin);
    chk({tag, ".gray"}, gray, ex.gry);
    chk({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ex.wrp});
    chk({tag, ".step_err"}, {7'd0, step_err}, {7'd0, ex.err});
    $display("%s rst_n=%b en=%b up=%b load=%b lv=%h -> bin=%h gray=%h wrap=%b err=%b",
             tag, rn, e, u, l, lv, binary, gray, wrap, step_err);
  endtask

  logic [N-1:0] up_gray [7];

  initial begin
    up_gray = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05};
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;

    // Reset overrides load and en
    step(0, 1, 1, 1, 8'h5A, "rst0");
    step(0, 1, 1, 1, 8'h5A, "rst1");
    chk("rst.binary", binary, 8'h00);
    chk("rst.gray", gray, 8'h00);

    // Up count Gray sequence
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 1, 0, 8'h00, "up");
      chk("up.gray_const", gray, up_gray[i]);
    end

    // Up wrap
    step(1, 0, 1, 1, 8'hFF, "ldFF");
    chk("ldFF.gray_const", gray, 8'h80);
    step(1, 1, 1, 0, 8'h00, "upwrap");
    chk("upwrap.wrap_const", {7'd0, wrap}, 8'h01);
    step(1, 0, 1, 0, 8'h00, "hold");
    chk("hold.wrap_const", {7'd0, wrap}, 8'h00);

    // Down wrap then immediate direction change
    step(0, 0, 1, 0, 8'h00, "rst2");
    step(1, 1, 0, 0, 8'h00, "dnwrap");
    chk("dnwrap.binary_const", binary, 8'hFF);
    chk("dnwrap.gray_const", gray, 8'h80);
    step(1, 1, 1, 0, 8'h00, "dirchg");
    chk("dirchg.wrap_const", {7'd0, wrap}, 8'h01);

    // Load priority over en
    step(1, 0, 1, 1, 8'h10, "ld10");
    step(1, 1, 1, 1, 8'hAA, "ldAA");
    chk("ldAA.gray_const", gray, 8'hFF);
    step(1, 1, 1, 0, 8'h00, "upAB");
    chk("upAB.binary_const", binary, 8'hAB);
    chk("upAB.gray_const", gray, 8'hFE);

    // Reset mid-count
    step(1, 0, 1, 1, 8'h37, "ld37");
    step(0, 1, 1, 0, 8'h00, "rstmid");
    chk("rstmid.binary_const", binary, 8'h00);

    // Random soak
    for (int i = 0; i < 1000; i++) begin
      logic l;
      l = ($urandom_range(99) < 5);
      step(1, 1'($urandom_range(1)), 1'($urandom_range(1)), l, 8'($urandom), "soak");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
